hazard_stall_unit: RTL



---
 rtl/mips_pkg.sv | 25 ++
 rtl/hazard_stall_unit_if.sv | 40 ++++
 rtl/sat_counter.sv | 23 ++
 rtl/hazard_stall_unit.sv | 74 +++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS pipeline hazard logic
// Contents: FSM state encoding, the hardwired-zero register index, the default
// stall-counter width, and the source-operand match helper.
package mips_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         CNT_W_DEFAULT = 16;

  // True when destination r feeds a source operand of the ID instruction.
  // $0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_match(
    input logic [4:0] r,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - pipeline-to-hazard-unit signal bundle
// master: pipeline side, drives ID/EX/MEM hazard inputs and i_Flush,
//         receives o_pc_write, o_if_id_write, o_id_ex_bubble, o_stall_count.
// slave : hazard_stall_unit side, the mirror image.
interface hazard_stall_unit_if
  import mips_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic [4:0]       i_ID_Rs;
  logic [4:0]       i_ID_Rt;
  logic             i_ID_UsesRt;
  logic             i_ID_Branch;
  logic             i_ID_Ex_MemRead;
  logic             i_ID_Ex_Regwrite;
  logic [4:0]       i_ID_Ex_WriteReg;
  logic             i_EX_MemMemRead;
  logic [4:0]       i_EX_MemWriteReg;
  logic             i_Flush;
  logic             o_pc_write;
  logic             o_if_id_write;
  logic             o_id_ex_bubble;
  logic [CNT_W-1:0] o_stall_count;

  modport master (
    output i_ID_Rs, i_ID_Rt, i_ID_UsesRt, i_ID_Branch,
    output i_ID_Ex_MemRead, i_ID_Ex_Regwrite, i_ID_Ex_WriteReg,
    output i_EX_MemMemRead, i_EX_MemWriteReg, i_Flush,
    input  o_pc_write, o_if_id_write, o_id_ex_bubble, o_stall_count
  );

  modport slave (
    input  i_ID_Rs, i_ID_Rt, i_ID_UsesRt, i_ID_Branch,
    input  i_ID_Ex_MemRead, i_ID_Ex_Regwrite, i_ID_Ex_WriteReg,
    input  i_EX_MemMemRead, i_EX_MemWriteReg, i_Flush,
    output o_pc_write, o_if_id_write, o_id_ex_bubble, o_stall_count
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit saturating up-counter with enable
// Ports: clk (rising edge), clr_n (asynchronous active-low clear),
//        en (count this edge), count (current value, sticks at all-ones).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use / branch-operand stall controller
// Ports: i_clk, i_rst_n (asynchronous active-low), hz (slave side of
//        hazard_stall_unit_if: ID/EX/MEM register fields, flush, and the
//        pc_write / if_id_write / id_ex_bubble controls plus stall count).
module hazard_stall_unit
  import mips_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  hazard_stall_unit_if.slave  hz
);

  state_t state;
  logic   ex_match;
  logic   mem_match;
  logic   need1;
  logic   need2;
  logic   stall;

  assign ex_match  = reg_match(hz.i_ID_Ex_WriteReg, hz.i_ID_Rs, hz.i_ID_Rt, hz.i_ID_UsesRt);
  assign mem_match = reg_match(hz.i_EX_MemWriteReg, hz.i_ID_Rs, hz.i_ID_Rt, hz.i_ID_UsesRt);

  // A branch compares in ID, so a load still in EX is two cycles short of
  // the MEM-to-ID forward path.
  assign need2 = hz.i_ID_Branch && hz.i_ID_Ex_MemRead && ex_match;

  assign need1 = !need2 && (
                   (!hz.i_ID_Branch && hz.i_ID_Ex_MemRead  && ex_match)  ||
                   ( hz.i_ID_Branch && hz.i_ID_Ex_Regwrite && ex_match)  ||
                   ( hz.i_ID_Branch && hz.i_EX_MemMemRead  && mem_match));

  // HOLD ignores the hazard inputs; the second stall cycle is unconditional.
  // Gating with reset keeps the pipeline running while reset is held.
  always_comb begin
    stall = 1'b0;
    if (i_rst_n && !hz.i_Flush) begin
      if (state == ST_HOLD) begin
        stall = 1'b1;
      end else begin
        stall = need1 || need2;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else if (hz.i_Flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state <= need2 ? ST_HOLD : ST_IDLE;
        ST_HOLD: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign hz.o_pc_write     = !stall;
  assign hz.o_if_id_write  = !stall;
  assign hz.o_id_ex_bubble = stall;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (i_clk),
    .clr_n (i_rst_n),
    .en    (stall),
    .count (hz.o_stall_count)
  );

endmodule
